// File: rtl/bitwise_pkg.sv
// Shared constants and types for the bitwise unit and its result serializer.
package bitwise_pkg;

    localparam int unsigned W     = 4;
    localparam int unsigned N     = 6;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // Result-index map, shared with the bitwise unit and the checker
    localparam int unsigned IDX_Y1 = 0;
    localparam int unsigned IDX_Y2 = 1;
    localparam int unsigned IDX_Y3 = 2;
    localparam int unsigned IDX_Y4 = 3;
    localparam int unsigned IDX_Y5 = 4;
    localparam int unsigned IDX_Y6 = 5;

endpackage

// File: rtl/bitwise_result_serializer.sv
// Captures six result words in one handshake and emits them one per beat, with a running XOR
// checksum reported once each set completes.
module bitwise_result_serializer
    import bitwise_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     y1,
    input  logic [W-1:0]     y2,
    input  logic [W-1:0]     y3,
    input  logic [W-1:0]     y4,
    input  logic [W-1:0]     y5,
    input  logic [W-1:0]     y6,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic [W-1:0]     chk,
    output logic             chk_valid
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     data_buf_q [N];
    logic [W-1:0]     data_buf_d [N];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     chk_q, chk_d;
    logic             chk_valid_q, chk_valid_d;

    logic is_last;
    logic beat_accept;
    logic capture;

    assign is_last   = (state_q == SEND) && (idx_q == LastIdx);
    assign out_valid = (state_q == SEND);
    assign out_data  = out_valid ? data_buf_q[idx_q] : '0;
    assign out_idx   = out_valid ? idx_q : '0;
    assign out_last  = is_last;
    assign chk       = chk_q;
    assign chk_valid = chk_valid_q;

    // Combinational out_ready path lets the next set land with no idle cycle
    assign in_ready    = (state_q == IDLE) || (is_last && out_ready);
    assign beat_accept = out_valid && out_ready;
    assign capture     = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        data_buf_d  = data_buf_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        chk_d       = chk_q;
        chk_valid_d = 1'b0;

        if (beat_accept) begin
            if (is_last) begin
                chk_d       = acc_q ^ out_data;
                chk_valid_d = 1'b1;
                state_d     = IDLE;
                idx_d       = '0;
                acc_d       = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
                acc_d = acc_q ^ out_data;
            end
        end

        // Capture wins over the return to IDLE when both happen on the last beat
        if (capture) begin
            data_buf_d[IDX_Y1] = y1;
            data_buf_d[IDX_Y2] = y2;
            data_buf_d[IDX_Y3] = y3;
            data_buf_d[IDX_Y4] = y4;
            data_buf_d[IDX_Y5] = y5;
            data_buf_d[IDX_Y6] = y6;
            idx_d              = '0;
            acc_d              = '0;
            state_d            = SEND;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_buf_q  <= '{default: '0};
            idx_q       <= '0;
            acc_q       <= '0;
            chk_q       <= '0;
            chk_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_buf_q  <= data_buf_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            chk_q       <= chk_d;
            chk_valid_q <= chk_valid_d;
        end
    end

endmodule

// File: tb/tb_bitwise_result_serializer.sv
// Directed bench for the result serializer: single set, stalls, back-to-back, reset, ignored input.
module tb_bitwise_result_serializer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] y1, y2, y3, y4, y5, y6;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [2:0] out_idx;
    logic       out_last;
    logic [3:0] chk;
    logic       chk_valid;

    int checks;
    int failures;

    logic [3:0] set_a [6];
    logic [3:0] set_b [6];

    bitwise_result_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .y4        (y4),
        .y5        (y5),
        .y6        (y6),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .chk       (chk),
        .chk_valid (chk_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_set(input logic [3:0] s [6]);
        y1 = s[0]; y2 = s[1]; y3 = s[2]; y4 = s[3]; y5 = s[4]; y6 = s[5];
    endtask

    // Present a set at a negedge in IDLE; returns at the negedge where beat 0 is visible
    task automatic capture_set(input logic [3:0] s [6]);
        drive_set(s);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        y1 = '0; y2 = '0; y3 = '0; y4 = '0; y5 = '0; y6 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        checks++;
        if ({out_data, out_idx, out_last} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%0d/%b want=0/0/0", out_data, out_idx, out_last);
        end
        checks++;
        if (chk !== 4'h0 || chk_valid !== 1'b0) begin
            failures++; $display("FAIL reset_chk got=%h/%b want=0/0", chk, chk_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_set;
        capture_set(set_a);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 3'(i) || out_data !== set_a[i]
                || out_last !== (i == 5)) begin
                failures++;
                $display("FAIL single_beat%0d got v=%b idx=%0d d=%h last=%b want v=1 idx=%0d d=%h last=%b",
                         i, out_valid, out_idx, out_data, out_last, i, set_a[i], (i == 5));
            end
            @(negedge clk);
        end
        checks++;
        if (chk_valid !== 1'b1 || chk !== 4'hF || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_chk got cv=%b chk=%h ov=%b want cv=1 chk=f ov=0",
                     chk_valid, chk, out_valid);
        end
        @(negedge clk);
        checks++;
        if (chk_valid !== 1'b0 || chk !== 4'hF) begin
            failures++; $display("FAIL single_chk_pulse got cv=%b chk=%h want cv=0 chk=f",
                                 chk_valid, chk);
        end
    endtask

    task automatic test_backpressure;
        capture_set(set_a);
        for (int i = 0; i < 6; i++) begin
            if (i == 2 || i == 4) begin
                out_ready = 1'b0;
                repeat (3) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_idx !== 3'(i) || out_data !== set_a[i]
                        || in_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL stall_beat%0d got v=%b idx=%0d d=%h ir=%b want v=1 idx=%0d d=%h ir=0",
                                 i, out_valid, out_idx, out_data, in_ready, i, set_a[i]);
                    end
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 3'(i) || out_data !== set_a[i]) begin
                failures++;
                $display("FAIL bp_beat%0d got v=%b idx=%0d d=%h want v=1 idx=%0d d=%h",
                         i, out_valid, out_idx, out_data, i, set_a[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (chk_valid !== 1'b1 || chk !== 4'hF || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_chk got cv=%b chk=%h ov=%b want cv=1 chk=f ov=0",
                     chk_valid, chk, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        capture_set(set_a);
        for (int i = 0; i < 5; i++) @(negedge clk);
        // Beat 5 is showing: present set B so it lands with the last-beat accept
        drive_set(set_b);
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_idx !== 3'd5 || out_last !== 1'b1) begin
            failures++; $display("FAIL b2b_ready got ir=%b idx=%0d last=%b want ir=1 idx=5 last=1",
                                 in_ready, out_idx, out_last);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (chk_valid !== 1'b1 || chk !== 4'hF) begin
            failures++; $display("FAIL b2b_chk1 got cv=%b chk=%h want cv=1 chk=f", chk_valid, chk);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 3'(i) || out_data !== set_b[i]) begin
                failures++;
                $display("FAIL b2b_beat%0d got v=%b idx=%0d d=%h want v=1 idx=%0d d=%h",
                         i, out_valid, out_idx, out_data, i, set_b[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (chk_valid !== 1'b1 || chk !== 4'h0) begin
            failures++; $display("FAIL b2b_chk2 got cv=%b chk=%h want cv=1 chk=0", chk_valid, chk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_set;
        capture_set(set_a);
        for (int i = 0; i < 3; i++) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || chk !== 4'h0 || out_idx !== 3'd0 || chk_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset got ov=%b chk=%h idx=%0d cv=%b want ov=0 chk=0 idx=0 cv=0",
                     out_valid, chk, out_idx, chk_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || chk_valid !== 1'b0) begin
                failures++;
                $display("FAIL post_reset%0d got ir=%b ov=%b cv=%b want ir=1 ov=0 cv=0",
                         i, in_ready, out_valid, chk_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignored_input;
        capture_set(set_a);
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 5) ? ((i % 2) == 0) : 1'b0;
            y1 = ~set_a[0] ^ 4'(i); y2 = ~set_a[1]; y3 = 4'(i); y4 = ~set_a[3];
            y5 = 4'(i + 7); y6 = ~set_a[5];
            #1;
            checks++;
            if (in_ready !== (i == 5) || out_idx !== 3'(i) || out_data !== set_a[i]) begin
                failures++;
                $display("FAIL ignored_beat%0d got ir=%b idx=%0d d=%h want ir=%b idx=%0d d=%h",
                         i, in_ready, out_idx, out_data, (i == 5), i, set_a[i]);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (chk_valid !== 1'b1 || chk !== 4'hF || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ignored_chk got cv=%b chk=%h ov=%b want cv=1 chk=f ov=0",
                     chk_valid, chk, out_valid);
        end
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        set_a[0] = 4'b0001; set_a[1] = 4'b1101; set_a[2] = 4'b1100;
        set_a[3] = 4'b1110; set_a[4] = 4'b0010; set_a[5] = 4'b0011;
        for (int i = 0; i < 6; i++) set_b[i] = 4'b1010;

        test_reset();
        test_single_set();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_set();
        test_ignored_input();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
